// File: rtl/sysid_checker.sv
// ============================================================================
//  Module      : sysid_checker
//  Description : Reads the system ID and timestamp words from a sysid slave,
//                compares them against the expected build values and reports
//                pass / per-word mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1300963752,
  parameter int          READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  mismatch,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Wait counter preload: the last wait cycle is the one where the counter reads zero.
  localparam logic [1:0] c_wait_init = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  if ((READ_LATENCY < 0) || (READ_LATENCY > 3)) begin : g_bad_latency
    $error("sysid_checker: READ_LATENCY must be within 0..3");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ID   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_RD_TS   = 3'd3,
    S_WAIT_TS = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic        auto_pend_q, auto_pend_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  mismatch_q, mismatch_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        begin_check;

  // Next-state, capture and registered-output computation.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    auto_pend_d = 1'b0;
    addr_d      = addr_q;
    done_d      = done_q;
    pass_d      = pass_q;
    mismatch_d  = mismatch_q;
    id_d        = id_q;
    ts_d        = ts_q;
    begin_check = start || auto_pend_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (begin_check) begin
          state_d    = S_RD_ID;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          mismatch_d = 2'b00;
        end
      end
      S_RD_ID: begin
        if (READ_LATENCY == 0) begin
          id_d    = sysid_readdata;
          state_d = S_RD_TS;
        end else begin
          wait_d  = c_wait_init;
          state_d = S_WAIT_ID;
        end
      end
      S_WAIT_ID: begin
        if (wait_q == 2'd0) begin
          id_d    = sysid_readdata;
          state_d = S_RD_TS;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_RD_TS: begin
        if (READ_LATENCY == 0) begin
          ts_d    = sysid_readdata;
          state_d = S_CHECK;
        end else begin
          wait_d  = c_wait_init;
          state_d = S_WAIT_TS;
        end
      end
      S_WAIT_TS: begin
        if (wait_q == 2'd0) begin
          ts_d    = sysid_readdata;
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_CHECK: begin
        mismatch_d = {(ts_q != EXPECTED_TIMESTAMP), (id_q != EXPECTED_ID)};
        pass_d     = (ts_q == EXPECTED_TIMESTAMP) && (id_q == EXPECTED_ID);
        done_d     = 1'b1;
        state_d    = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus strobes and busy are decoded from the next state so they are glitch-free flops.
    read_d = (state_d == S_RD_ID) || (state_d == S_RD_TS);
    if (state_d == S_RD_ID) begin
      addr_d = 1'b0;
    end else if (state_d == S_RD_TS) begin
      addr_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers; reset abandons any check in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 2'd0;
      auto_pend_q <= AUTO_START;
      read_q      <= 1'b0;
      addr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mismatch_q  <= 2'b00;
      id_q        <= 32'd0;
      ts_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      auto_pend_q <= auto_pend_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      mismatch_q  <= mismatch_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
    end
  end

  assign sysid_read    = read_q;
  assign sysid_address = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch      = mismatch_q;
  assign id_value      = id_q;
  assign ts_value      = ts_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_checker.sv
// ============================================================================
//  Module      : tb_sysid_checker
//  Description : Scoreboard bench for sysid_checker across three parameter
//                sets (latency 0/auto, latency 2/auto, latency 1/manual).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sysid_checker;

  localparam int N = 3;

  typedef struct {
    logic        pass;
    logic [1:0]  mm;
    logic [31:0] id;
    logic [31:0] ts;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        rst_n          [N];
  logic        start          [N];
  logic [31:0] id_word        [N];
  logic [31:0] ts_word        [N];
  logic        sysid_address  [N];
  logic        sysid_read     [N];
  logic [31:0] readdata       [N];
  logic        busy           [N];
  logic        done           [N];
  logic        pass           [N];
  logic [1:0]  mismatch       [N];
  logic [31:0] id_value       [N];
  logic [31:0] ts_value       [N];
  exp_t        exp_q          [N][$];
  int          busy_until     [N];
  int          rd_total       [N];

  function automatic int lat(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic logic [31:0] exp_id(input int i);
    return (i == 1) ? 32'h1234_5678 : 32'd0;
  endfunction
  function automatic logic [31:0] exp_ts(input int i);
    return (i == 1) ? 32'hCAFE_F00D : 32'd1300963752;
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h (cycle %0d)", name, i, act, req, cyc);
    end
  endtask

  // Expected outcome of a check that begins at the next rising edge.
  task automatic push_check(input int i);
    exp_t e;
    e.id       = id_word[i];
    e.ts       = ts_word[i];
    e.pass     = (e.id == exp_id(i)) && (e.ts == exp_ts(i));
    e.mm       = {(e.ts != exp_ts(i)), (e.id != exp_id(i))};
    e.done_cyc = cyc + 4 + 2 * lat(i);
    exp_q[i].push_back(e);
    busy_until[i] = e.done_cyc;
  endtask

  // Raise start; the model accepts it only if no check is in progress.
  task automatic try_start(input int i);
    start[i] = 1'b1;
    if (cyc >= busy_until[i]) push_check(i);
  endtask

  task automatic wait_idle(input int i);
    while (cyc < busy_until[i]) @(negedge clk);
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int          LAT  = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam logic [31:0] EID  = (g == 1) ? 32'h1234_5678 : 32'd0;
    localparam logic [31:0] ETS  = (g == 1) ? 32'hCAFE_F00D : 32'd1300963752;
    localparam bit          AUTO = (g == 2) ? 1'b0 : 1'b1;

    logic [31:0] word;
    assign word = sysid_address[g] ? ts_word[g] : id_word[g];

    if (LAT == 0) begin : g_comb
      assign readdata[g] = word;
    end else begin : g_dly
      logic [31:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= word;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign readdata[g] = pipe[LAT-1];
    end

    sysid_checker #(
      .EXPECTED_ID        (EID),
      .EXPECTED_TIMESTAMP (ETS),
      .READ_LATENCY       (LAT),
      .AUTO_START         (AUTO)
    ) u_dut (
      .clock          (clk),
      .reset_n        (rst_n[g]),
      .start          (start[g]),
      .sysid_address  (sysid_address[g]),
      .sysid_read     (sysid_read[g]),
      .sysid_readdata (readdata[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .mismatch       (mismatch[g]),
      .id_value       (id_value[g]),
      .ts_value       (ts_value[g])
    );

    // Monitor: checks read order per check and pops the scoreboard on each done rise.
    initial begin
      int   rdcnt;
      logic done_prev;
      exp_t e;
      rdcnt     = 0;
      done_prev = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n[g]) begin
          rdcnt     = 0;
          done_prev = 1'b0;
        end else begin
          if (sysid_read[g]) begin
            chk("read_addr", g, {63'd0, sysid_address[g]}, rdcnt);
            rdcnt++;
            rd_total[g]++;
          end
          if (done[g] && !done_prev) begin
            if (exp_q[g].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_done dut%0d actual=done required=no_done (cycle %0d)", g, cyc);
            end else begin
              e = exp_q[g].pop_front();
              chk("done_cycle", g, cyc, e.done_cyc);
              chk("pass", g, {63'd0, pass[g]}, {63'd0, e.pass});
              chk("mismatch", g, {62'd0, mismatch[g]}, {62'd0, e.mm});
              chk("id_value", g, {32'd0, id_value[g]}, {32'd0, e.id});
              chk("ts_value", g, {32'd0, ts_value[g]}, {32'd0, e.ts});
              chk("read_count", g, rdcnt, 2);
              chk("busy_in_done", g, {63'd0, busy[g]}, 64'd0);
            end
            rdcnt = 0;
          end
          done_prev = done[g];
        end
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < N; i++) begin
      rst_n[i]      = 1'b0;
      start[i]      = 1'b0;
      busy_until[i] = -1;
      rd_total[i]   = 0;
    end
    id_word[0] = 32'd0;          ts_word[0] = 32'd1300963752;
    id_word[1] = 32'h1234_5678;  ts_word[1] = 32'hCAFE_F00D;
    id_word[2] = 32'd0;          ts_word[2] = 32'd1300963752;

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("reset_ctrl", i, {57'd0, sysid_address[i], sysid_read[i], busy[i], done[i], pass[i], mismatch[i]}, 64'd0);
      chk("reset_words", i, {id_value[i], ts_value[i]}, 64'd0);
    end

    // Release: the auto-start instances begin a check on the first edge.
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b1;
      if (i != 2) push_check(i);
    end

    // Manual-start instance must stay quiet with start low.
    repeat (20) @(negedge clk);
    chk("noauto_reads", 2, rd_total[2], 0);
    chk("noauto_done", 2, {63'd0, done[2]}, 64'd0);

    // ID word mismatch on instance 0.
    wait_idle(0);
    id_word[0] = 32'd1;
    try_start(0);
    @(negedge clk) start[0] = 1'b0;

    // Start while busy is ignored; start in DONE restarts and drops done.
    wait_idle(0);
    id_word[0] = 32'd0;
    try_start(0);
    @(negedge clk) start[0] = 1'b0;
    @(negedge clk) try_start(0);
    @(negedge clk) start[0] = 1'b0;
    wait_idle(0);
    chk("done_before_restart", 0, {63'd0, done[0]}, 64'd1);
    try_start(0);
    @(negedge clk) start[0] = 1'b0;
    chk("done_drops", 0, {63'd0, done[0]}, 64'd0);

    // Reset in the middle of the timestamp wait on the latency-2 instance.
    wait_idle(1);
    try_start(1);
    @(negedge clk) start[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_wait_ts", 1, {63'd0, busy[1]}, 64'd1);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("midreset_ctrl", 1, {57'd0, sysid_address[1], sysid_read[1], busy[1], done[1], pass[1], mismatch[1]}, 64'd0);
    chk("midreset_words", 1, {id_value[1], ts_value[1]}, 64'd0);
    exp_q[1].delete();
    busy_until[1] = -1;
    @(negedge clk);
    rst_n[1] = 1'b1;
    push_check(1);

    // Randomized traffic: random words while idle, random start pulses and holds.
    repeat (400) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        start[i] = 1'b0;
        if ((cyc >= busy_until[i]) && ($urandom_range(0, 3) == 0)) begin
          id_word[i] = ($urandom_range(0, 1) == 1) ? exp_id(i) : $urandom;
          ts_word[i] = ($urandom_range(0, 1) == 1) ? exp_ts(i) : $urandom;
        end
        if ($urandom_range(0, 3) == 0) try_start(i);
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) start[i] = 1'b0;

    guard = 0;
    while (((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 0, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
